// File: rtl/rx_frame_ctrl.sv
// Receive-side frame controller for the UART receiver.
// Synchronizes the serial line, validates the start bit at mid-bit, issues
// one shift_strobe at the centre of every data and stop bit, checks the stop
// bit reported back by the shift register, then either pulses load_buffer or
// raises the sticky framing_error flag.
module rx_frame_ctrl #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   input  logic stop_bit,
   output logic shift_strobe,
   output logic load_buffer,
   output logic framing_error,
   output logic busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
   localparam int BW   = $clog2(DATA_BITS + 2);
   localparam int HALF = CLKS_PER_BIT / 2;

   // Last cycle of the half-bit start validation window.
   localparam logic [CW-1:0] HALF_LAST   = CW'(HALF - 1);
   // clk_cnt value during the cycle a strobe is visible.
   localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
   // One cycle earlier: the strobe register is loaded here.
   localparam logic [CW-1:0] BIT_PRE     = CW'(CLKS_PER_BIT - 2);
   // bit_cnt value while the final (stop-bit) strobe is visible.
   localparam logic [BW-1:0] LAST_STROBE = BW'(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START_CHK,
      RECV,
      STOP_CHK,
      LOAD
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            meta;
   logic            sync;
   logic            sync_prev;
   logic [CW-1:0]   clk_cnt;
   logic [CW-1:0]   clk_cnt_nxt;
   logic [BW-1:0]   bit_cnt;
   logic [BW-1:0]   bit_cnt_nxt;
   logic            strobe_nxt;
   logic            load_nxt;
   logic            ferr_nxt;
   logic            start_det;

   // Two-flop synchronizer plus an edge-history flop; all idle high.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         meta      <= 1'b1;
         sync      <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         meta      <= serial_in;
         sync      <= meta;
         sync_prev <= sync;
      end
   end

   // A falling edge on the synchronized line only counts as a start in IDLE.
   assign start_det = (state == IDLE) && !sync && sync_prev;

   assign busy = (state != IDLE);

   // Next-state, counter and output decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt + 1'b1;
      bit_cnt_nxt = bit_cnt;
      strobe_nxt  = 1'b0;
      load_nxt    = 1'b0;
      ferr_nxt    = framing_error;

      case (state)
         IDLE: begin
            clk_cnt_nxt = '0;
            if (start_det) begin
               state_nxt = START_CHK;
               ferr_nxt  = 1'b0;
            end
         end

         START_CHK: begin
            // Mid-bit sample: a line that is high again was only a glitch.
            if (clk_cnt == HALF_LAST) begin
               state_nxt = sync ? IDLE : RECV;
            end
         end

         RECV: begin
            // The strobe register is loaded one cycle ahead so the pulse is
            // visible exactly on the terminal count.
            if (clk_cnt == BIT_PRE) begin
               strobe_nxt = 1'b1;
            end
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_nxt = '0;
               bit_cnt_nxt = bit_cnt + 1'b1;
               if (bit_cnt == LAST_STROBE) begin
                  state_nxt = STOP_CHK;
               end
            end
         end

         STOP_CHK: begin
            // The stop bit has already been shifted into bit 0.
            if (stop_bit) begin
               state_nxt = LOAD;
               load_nxt  = 1'b1;
            end else begin
               state_nxt = IDLE;
               ferr_nxt  = 1'b1;
            end
         end

         LOAD: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Both counters restart from zero on every state entry.
      if (state_nxt != state) begin
         clk_cnt_nxt = '0;
         bit_cnt_nxt = '0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         clk_cnt       <= '0;
         bit_cnt       <= '0;
         shift_strobe  <= 1'b0;
         load_buffer   <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_nxt;
         clk_cnt       <= clk_cnt_nxt;
         bit_cnt       <= bit_cnt_nxt;
         shift_strobe  <= strobe_nxt;
         load_buffer   <= load_nxt;
         framing_error <= ferr_nxt;
      end
   end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl.
// Frames are predicted from their bit timing with plain arithmetic; the
// predictions are queued and a negedge monitor pops and compares them
// whenever the DUT emits a strobe, a load or a framing_error change. The
// downstream 9-bit shift register is modelled so stop_bit and the received
// packet come from the bits the DUT actually strobed.
module tb_rx_frame_ctrl;

   localparam int P        = 10;
   localparam int N        = 8;
   localparam int H        = P / 2;
   localparam int CLK_HALF = 5;

   logic tb_clk    = 1'b0;
   logic rst       = 1'b1;
   logic serial_in = 1'b1;
   logic stop_bit;
   logic shift_strobe;
   logic load_buffer;
   logic framing_error;
   logic busy;

   always #CLK_HALF tb_clk = ~tb_clk;

   rx_frame_ctrl #(
      .CLKS_PER_BIT (P),
      .DATA_BITS    (N)
   ) dut (
      .clk           (tb_clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .stop_bit      (stop_bit),
      .shift_strobe  (shift_strobe),
      .load_buffer   (load_buffer),
      .framing_error (framing_error),
      .busy          (busy)
   );

   typedef enum int {EV_STROBE, EV_LOAD, EV_FE_RISE, EV_FE_FALL} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      int         cyc;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   bit         exp_busy[int];
   int         cyc      = 0;
   int         n_tests  = 0;
   int         n_fail   = 0;
   bit         mon_en   = 1'b0;
   logic       fe_prev  = 1'b0;
   bit         model_fe = 1'b0;
   logic [8:0] sr       = '0;

   // Cycle index: cycle c is the interval after the c-th rising edge.
   always @(posedge tb_clk) cyc <= cyc + 1;

   // Downstream shift register: shifts serial_in in on the edge after a strobe.
   always @(posedge tb_clk) if (shift_strobe === 1'b1) sr <= {sr[7:0], serial_in};
   assign stop_bit = sr[0];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, got, exp);
      end
   endtask

   function automatic void push_ev(input ev_kind_t k, input int c, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   function automatic void mark_busy(input int a, input int b);
      for (int c = a; c <= b; c++) exp_busy[c] = 1'b1;
   endfunction

   // First data bit lands in sr[8], the stop bit in sr[0].
   function automatic logic [7:0] pkt_of(input logic [8:0] s);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = s[8-i];
      return p;
   endfunction

   // Frame whose start bit begins in cycle t; r >= 0 is a cycle with rst high.
   function automatic void predict_frame(input int t, input logic [7:0] d, input bit stop, input int r);
      int dc;
      int chk;
      dc  = t + 2;
      chk = dc + H + (N + 1) * P + 1;
      if (model_fe) begin
         push_ev(EV_FE_FALL, dc + 1, 8'h00);
         model_fe = 1'b0;
      end
      for (int k = 1; k <= N + 1; k++) begin
         if (r < 0 || dc + H + k * P <= r) push_ev(EV_STROBE, dc + H + k * P, 8'h00);
      end
      if (r >= 0) begin
         mark_busy(dc + 1, r);
      end else if (stop) begin
         push_ev(EV_LOAD, chk + 1, d);
         mark_busy(dc + 1, chk + 1);
      end else begin
         push_ev(EV_FE_RISE, chk + 1, 8'h00);
         model_fe = 1'b1;
         mark_busy(dc + 1, chk);
      end
   endfunction

   function automatic void predict_false(input int t);
      int dc;
      dc = t + 2;
      if (model_fe) begin
         push_ev(EV_FE_FALL, dc + 1, 8'h00);
         model_fe = 1'b0;
      end
      mark_busy(dc + 1, dc + H);
   endfunction

   task automatic observe(input ev_kind_t k, input logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event (cycle %0d): got %s, required none", cyc, k.name());
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(k), 32'(e.kind));
         check("event_cycle", 32'(cyc), 32'(e.cyc));
         if (k == EV_LOAD && e.kind == EV_LOAD) check("packet", 32'(d), 32'(e.data));
      end
   endtask

   // Monitor: busy every cycle, plus every output event against the queue.
   always @(negedge tb_clk) begin
      if (mon_en) begin
         check("busy", 32'(busy), exp_busy.exists(cyc) ? 32'd1 : 32'd0);
         if (shift_strobe !== 1'b0) observe(EV_STROBE, 8'h00);
         if (load_buffer !== 1'b0) observe(EV_LOAD, pkt_of(sr));
         if (framing_error !== fe_prev) observe(framing_error ? EV_FE_RISE : EV_FE_FALL, 8'h00);
         fe_prev = framing_error;
      end
   end

   task automatic step();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         serial_in = 1'b1;
      end
   endtask

   // abort_at >= 0: rst is raised that many cycles after the start bit begins.
   task automatic send_frame(input logic [7:0] d, input bit stop, input int abort_at);
      logic [9:0] bits;
      int t;
      bits = {stop, d, 1'b0};
      step();
      t = cyc;
      predict_frame(t, d, stop, (abort_at < 0) ? -1 : t + abort_at);
      for (int c = 0; c < 10 * P; c++) begin
         if (c > 0) step();
         if (abort_at >= 0 && c == abort_at) begin
            rst       = 1'b1;
            serial_in = 1'b1;
            step();
            rst = 1'b0;
            check("abort_shift_strobe", 32'(shift_strobe), 32'd0);
            check("abort_load_buffer", 32'(load_buffer), 32'd0);
            check("abort_framing_error", 32'(framing_error), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            return;
         end
         serial_in = bits[c / P];
      end
   endtask

   task automatic false_start(input int len);
      int t;
      step();
      t = cyc;
      predict_false(t);
      serial_in = 1'b0;
      repeat (len - 1) step();
      step();
      serial_in = 1'b1;
   endtask

   initial begin
      logic [7:0] rd;
      bit         rstop;
      bit         prev_false;
      bit         prev_stop0;
      int         gap;

      // Reset held two cycles while the line toggles.
      rst       = 1'b1;
      serial_in = 1'b1;
      step();
      serial_in = 1'b0;
      check("rst_shift_strobe", 32'(shift_strobe), 32'd0);
      check("rst_load_buffer", 32'(load_buffer), 32'd0);
      check("rst_framing_error", 32'(framing_error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      step();
      rst       = 1'b0;
      serial_in = 1'b1;
      check("post_rst_shift_strobe", 32'(shift_strobe), 32'd0);
      check("post_rst_load_buffer", 32'(load_buffer), 32'd0);
      check("post_rst_framing_error", 32'(framing_error), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      mon_en = 1'b1;
      idle(10);

      // Directed scenarios.
      send_frame(8'hA5, 1'b1, -1);
      idle(10);
      false_start(3);
      idle(12);
      send_frame(8'h3C, 1'b0, -1);
      idle(30);
      send_frame(8'h96, 1'b1, -1);
      idle(10);
      send_frame(8'h5A, 1'b1, 2 + H + 4 * P + 1);
      idle(10);
      send_frame(8'h5A, 1'b1, -1);
      idle(10);
      send_frame(8'hFF, 1'b1, -1);
      send_frame(8'h00, 1'b1, -1);
      idle(10);

      // Random frames, false starts and gaps.
      prev_false = 1'b0;
      prev_stop0 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         gap = int'($urandom_range(0, 12));
         if (prev_false) gap = gap + 10;
         if (prev_stop0 && gap < 1) gap = 1;
         idle(gap);
         if ($urandom_range(0, 7) == 0) begin
            false_start(int'($urandom_range(1, H)));
            prev_false = 1'b1;
            prev_stop0 = 1'b0;
         end else begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rd, rstop, -1);
            prev_false = 1'b0;
            prev_stop0 = !rstop;
         end
      end

      idle(20);
      check("events_outstanding", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #(2 * CLK_HALF * 60000);
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
